// File: rtl/cr16_loader_pkg.sv
// rtl/cr16_loader_pkg.sv - shared types and constants for the CR16 serial image loader
//
// Contents:
//   P_LOADER_HEADER         frame start byte
//   P_DEFAULT_CLKS_PER_BIT  50 MHz / 115200 baud
//   loader_state_t          frame FSM states of bram_uart_loader
//   rx_state_t              bit-level FSM states of uart_rx
package cr16_loader_pkg;

    localparam logic [7:0] P_LOADER_HEADER        = 8'hA5;
    localparam int         P_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/bram_uart_loader_uart_rx.sv
// rtl/bram_uart_loader_uart_rx.sv - 8N1 UART receiver used by the serial image loader
//
// Ports:
//   I_CLK          system clock
//   I_NRESET       asynchronous active-low reset
//   I_UART_RX      raw serial line, idles high
//   O_BYTE         last received byte (valid while O_VALID is high)
//   O_VALID        one-cycle pulse at the stop-bit mid-sample of a good byte
//   O_FRAME_ERROR  one-cycle pulse when the stop bit is sampled low
module uart_rx
    import cr16_loader_pkg::*;
#(
    parameter int P_CLKS_PER_BIT = P_DEFAULT_CLKS_PER_BIT
) (
    input  logic       I_CLK,
    input  logic       I_NRESET,
    input  logic       I_UART_RX,
    output logic [7:0] O_BYTE,
    output logic       O_VALID,
    output logic       O_FRAME_ERROR
);

    localparam int            CW        = $clog2(P_CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(P_CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          ferr_q;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= I_UART_RX;
            sync2_q <= sync1_q;
            // prev_q tracks the line in every state so a start bit that
            // directly follows a stop bit still shows up as a falling edge.
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    baud_q <= '0;
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_q == HALF_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        // Line back high at mid start bit: glitch, not a start.
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_q == FULL_LAST) begin
                        baud_q  <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_q == FULL_LAST) begin
                        baud_q  <= '0;
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign O_BYTE        = byte_q;
    assign O_VALID       = valid_q;
    assign O_FRAME_ERROR = ferr_q;

endmodule

// File: rtl/bram_uart_loader.sv
// rtl/bram_uart_loader.sv - loads a framed program image from UART into BRAM and gates CR16 reset
//
// Ports:
//   I_CLK, I_NRESET      clock, asynchronous active-low reset
//   I_UART_RX            serial line carrying A5 / N(be16) / N words (hi first) / XOR
//   O_MEM_DATA           BRAM port A write data
//   O_MEM_ADDRESS        BRAM port A write address (counts from 0)
//   O_MEM_WRITE_ENABLE   one-cycle write strobe per assembled word
//   O_LOADING            loader owns BRAM port A
//   O_CPU_NRESET         CR16 reset, released only after an accepted image
//   O_DONE               last frame accepted
//   O_ERROR              last frame rejected
//   O_WORD_COUNT         words written in the current frame
module bram_uart_loader
    import cr16_loader_pkg::*;
#(
    parameter int P_CLKS_PER_BIT  = P_DEFAULT_CLKS_PER_BIT,
    parameter int P_ADDRESS_WIDTH = 10,
    parameter int P_DATA_WIDTH    = 16
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_UART_RX,
    output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    output logic                       O_MEM_WRITE_ENABLE,
    output logic                       O_LOADING,
    output logic                       O_CPU_NRESET,
    output logic                       O_DONE,
    output logic                       O_ERROR,
    output logic [15:0]                O_WORD_COUNT
);

    localparam int unsigned MAX_WORDS = 32'd1 << P_ADDRESS_WIDTH;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .P_CLKS_PER_BIT(P_CLKS_PER_BIT)
    ) u_rx (
        .I_CLK         (I_CLK),
        .I_NRESET      (I_NRESET),
        .I_UART_RX     (I_UART_RX),
        .O_BYTE        (rx_byte),
        .O_VALID       (rx_valid),
        .O_FRAME_ERROR (rx_ferr)
    );

    loader_state_t              state_q;
    logic [7:0]                 cnt_hi_q;
    logic [15:0]                n_q;
    logic [7:0]                 hi_q;
    logic [7:0]                 csum_q;
    logic [P_ADDRESS_WIDTH-1:0] addr_q;
    logic [15:0]                wcount_q;
    logic [P_DATA_WIDTH-1:0]    mem_data_q;
    logic                       mem_we_q;
    logic                       loading_q;
    logic                       cpu_nreset_q;
    logic                       done_q;
    logic                       error_q;

    logic [15:0] count_rx;
    assign count_rx = {cnt_hi_q, rx_byte};

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q      <= ST_IDLE;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            addr_q       <= '0;
            wcount_q     <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            loading_q    <= 1'b0;
            cpu_nreset_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            // Address/count advance the cycle after the strobe so they stay
            // stable while BRAM is written.
            if (mem_we_q) begin
                addr_q   <= addr_q + 1'b1;
                wcount_q <= wcount_q + 16'd1;
            end
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (rx_valid && rx_byte == P_LOADER_HEADER) begin
                        state_q      <= ST_CNT_HI;
                        loading_q    <= 1'b1;
                        cpu_nreset_q <= 1'b0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        addr_q       <= '0;
                        wcount_q     <= '0;
                        csum_q       <= '0;
                    end
                end
                default: begin
                    if (rx_ferr) begin
                        state_q      <= ST_ERROR;
                        loading_q    <= 1'b0;
                        cpu_nreset_q <= 1'b0;
                        error_q      <= 1'b1;
                    end else if (rx_valid) begin
                        if (state_q != ST_CHECK) begin
                            csum_q <= csum_q ^ rx_byte;
                        end
                        case (state_q)
                            ST_CNT_HI: begin
                                cnt_hi_q <= rx_byte;
                                state_q  <= ST_CNT_LO;
                            end
                            ST_CNT_LO: begin
                                n_q <= count_rx;
                                if (32'(count_rx) > MAX_WORDS) begin
                                    state_q      <= ST_ERROR;
                                    loading_q    <= 1'b0;
                                    cpu_nreset_q <= 1'b0;
                                    error_q      <= 1'b1;
                                end else if (count_rx == 16'd0) begin
                                    state_q <= ST_CHECK;
                                end else begin
                                    state_q <= ST_DATA_HI;
                                end
                            end
                            ST_DATA_HI: begin
                                hi_q    <= rx_byte;
                                state_q <= ST_DATA_LO;
                            end
                            ST_DATA_LO: begin
                                mem_data_q <= P_DATA_WIDTH'({hi_q, rx_byte});
                                mem_we_q   <= 1'b1;
                                // wcount_q has not yet counted this word.
                                state_q    <= (wcount_q + 16'd1 == n_q) ? ST_CHECK : ST_DATA_HI;
                            end
                            ST_CHECK: begin
                                loading_q <= 1'b0;
                                if (rx_byte == csum_q) begin
                                    state_q      <= ST_DONE;
                                    cpu_nreset_q <= 1'b1;
                                    done_q       <= 1'b1;
                                end else begin
                                    state_q      <= ST_ERROR;
                                    cpu_nreset_q <= 1'b0;
                                    error_q      <= 1'b1;
                                end
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign O_MEM_DATA         = mem_data_q;
    assign O_MEM_ADDRESS      = addr_q;
    assign O_MEM_WRITE_ENABLE = mem_we_q;
    assign O_LOADING          = loading_q;
    assign O_CPU_NRESET       = cpu_nreset_q;
    assign O_DONE             = done_q;
    assign O_ERROR            = error_q;
    assign O_WORD_COUNT       = wcount_q;

endmodule
